// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
//
// Sequential shift-and-add multiplier with a start/done handshake. One adder
// is reused over WIDTH iterations, consuming one multiplier bit per clock.
// Each operation may be signed (two's complement) or unsigned. Signed
// operands are reduced to magnitudes before the loop. The sign is applied
// once, when the result is written.
//
// Parameters
//   WIDTH  operand width in bits (>= 2); the product is 2*WIDTH bits
//
// Ports
//   clk    in   1          clock, all state changes on the rising edge
//   rst    in   1          synchronous active-high reset
//   start  in   1          operation request, honoured only while idle
//   in_a   in   WIDTH      multiplicand, captured with an accepted start
//   in_b   in   WIDTH      multiplier, captured with an accepted start
//   sgn    in   1          1 = two's-complement operands, 0 = unsigned
//   busy   out  1          high while an operation is in progress
//   done   out  1          one-cycle pulse; out is valid from this cycle
//   out    out  2*WIDTH    product, held until the next completion
//
// Build option
//   SEQ_MULT_EARLY_EXIT_EN  when defined, the operation finishes as soon as
//                           the remaining multiplier bits are all zero.
//                           Results are unchanged; only latency shrinks.
//                           When undefined, latency is always WIDTH+1.
// ---------------------------------------------------------------------------
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 sgn,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   out
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;
  logic             neg;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             accept;
  logic             iterate;
  logic             finish;

  // Operand magnitudes. The most negative value negates to itself. Read as
  // unsigned, that bit pattern is exactly 2^(WIDTH-1), so no extra bit is
  // needed.
  always_comb begin
    mag_a = in_a;
    mag_b = in_b;
    if (sgn && in_a[WIDTH-1]) begin
      mag_a = -in_a;
    end
    if (sgn && in_b[WIDTH-1]) begin
      mag_b = -in_b;
    end
  end

  // Control decode and next-state logic.
  // In RUN, every edge is either an iteration edge or the finish edge.
  // The iteration count normally ends the loop. With early exit, an
  // exhausted multiplier register ends it sooner. The count check stays in
  // that build as well; it coincides with an empty multiplier anyway.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    iterate    = 1'b0;
    finish     = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
`ifdef SEQ_MULT_EARLY_EXIT_EN
        finish = (mplier == '0) || (count == CW'(WIDTH));
`else
        finish = (count == CW'(WIDTH));
`endif
        iterate = !finish;
        if (finish) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register. Reset wins over everything, which aborts an operation
  // in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath registers.
  // On accept, the magnitudes are loaded and the accumulator and count are
  // cleared. The product sign is decided here from the raw operand MSBs.
  // Each iteration conditionally adds the shifted multiplicand and consumes
  // one multiplier bit. The finish edge applies the sign, publishes the
  // result and raises done for exactly one cycle. Reset clears out too.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      count  <= '0;
      neg    <= 1'b0;
      done   <= 1'b0;
      out    <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        mcand  <= {{WIDTH{1'b0}}, mag_a};
        mplier <= mag_b;
        acc    <= '0;
        count  <= '0;
        neg    <= sgn & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
      end else if (iterate) begin
        if (mplier[0]) begin
          acc <= acc + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + CW'(1);
      end else if (finish) begin
        out  <= neg ? -acc : acc;
        done <= 1'b1;
      end
    end
  end

  // busy is the RUN state seen from outside. It falls on the finish edge,
  // in the same cycle that done rises.
  assign busy = (state == RUN);

endmodule

// File: tb/tb_seq_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_multiplier
//
// Drives a WIDTH=4 and a WIDTH=8 seq_multiplier from one stimulus process.
//
// A reference process runs on each rising edge. It works out from the
// operand values alone when a start is honoured and how long the operation
// takes. It then queues the expected product with the cycle of its finish
// edge.
//
// A monitor process runs on each falling edge. It checks busy, done and out
// for both instances, and pops a queued result whenever a completion is due.
// ---------------------------------------------------------------------------
module tb_seq_multiplier;

  typedef struct {
    int          inst;
    logic [15:0] prod;
    int          fin;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [1:0]       startv;
  logic [1:0]       sgnv;
  logic [1:0][7:0]  av;
  logic [1:0][7:0]  bv;

  logic             busy4;
  logic             done4;
  logic [7:0]       out4;
  logic             busy8;
  logic             done8;
  logic [15:0]      out8;

  logic [1:0]       busyv;
  logic [1:0]       donev;
  logic [1:0][15:0] outv;

  exp_t             sbq[$];
  int               cycle = 0;
  int               nextOk[2];
  bit               rstAtEdge = 1'b0;
  logic [15:0]      lastOut[2] = '{16'h0000, 16'h0000};
  int               total = 0;
  int               bad = 0;

  assign busyv = {busy8, busy4};
  assign donev = {done8, done4};
  assign outv  = {out8, 8'h00, out4};

  seq_multiplier #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (startv[0]),
    .in_a  (av[0][3:0]),
    .in_b  (bv[0][3:0]),
    .sgn   (sgnv[0]),
    .busy  (busy4),
    .done  (done4),
    .out   (out4)
  );

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (startv[1]),
    .in_a  (av[1]),
    .in_b  (bv[1]),
    .sgn   (sgnv[1]),
    .busy  (busy8),
    .done  (done8),
    .out   (out8)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Integer value of a w-bit operand under the chosen signedness.
  function automatic longint opVal(int w, logic [7:0] x, logic s);
    longint v;
    v = 0;
    for (int k = 0; k < w; k++) begin
      if (x[k]) v += (longint'(1) << k);
    end
    if (s && x[w-1]) v -= (longint'(1) << w);
    return v;
  endfunction

  // Mathematical product truncated to 2*w bits.
  function automatic logic [15:0] refProd(int w, logic [7:0] a, logic [7:0] b, logic s);
    longint      p;
    logic [63:0] u;
    logic [63:0] mask;
    p    = opVal(w, a, s) * opVal(w, b, s);
    u    = p;
    mask = (64'd1 << (2 * w)) - 64'd1;
    return 16'(u & mask);
  endfunction

  // Number of edges from the accepting edge to the finish edge.
  function automatic int refLat(int w, logic [7:0] b, logic s);
`ifdef SEQ_MULT_EARLY_EXIT_EN
    longint m;
    int     k;
    m = opVal(w, b, s);
    if (m < 0) m = -m;
    if (m == 0) return 1;
    k = 0;
    for (int j = 0; j < w; j++) begin
      if (((m >> j) & 1) != 0) k = j;
    end
    return k + 2;
`else
    longint unusedM;
    unusedM = opVal(w, b, s);
    return (unusedM == unusedM) ? w + 1 : w + 1;
`endif
  endfunction

  task automatic checkOutput(string name, int i, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s dut%0d cycle %0d: got %h expected %h", name, i, cycle, act, exp);
    end
  endtask

  task automatic waitCycles(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic waitIdle(int i);
    while (cycle < nextOk[i]) waitCycles(1);
  endtask

  // Present one request so that the next edge is one where the block is idle.
  task automatic applyStimulus(int i, logic [7:0] a, logic [7:0] b, logic s);
    while (cycle + 1 < nextOk[i]) waitCycles(1);
    av[i]     = a;
    bv[i]     = b;
    sgnv[i]   = s;
    startv[i] = 1'b1;
    waitCycles(1);
    startv[i] = 1'b0;
  endtask

  // Reference: decide acceptances and queue expected completions.
  initial begin
    nextOk[0] = 0;
    nextOk[1] = 0;
    forever begin
      @(posedge clk);
      cycle++;
      rstAtEdge = rst;
      if (rst) begin
        sbq.delete();
        nextOk[0] = cycle + 1;
        nextOk[1] = cycle + 1;
      end else begin
        for (int i = 0; i < 2; i++) begin
          int w;
          int lat;
          w = (i == 0) ? 4 : 8;
          if (startv[i] && cycle >= nextOk[i]) begin
            lat = refLat(w, bv[i], sgnv[i]);
            sbq.push_back('{inst: i, prod: refProd(w, av[i], bv[i], sgnv[i]), fin: cycle + lat});
            nextOk[i] = cycle + lat + 1;
          end
        end
      end
    end
  end

  // Monitor: compare the DUT outputs against the scoreboard every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (cycle > 0) begin
        for (int i = 0; i < 2; i++) begin
          bit eDone;
          bit eBusy;
          eDone = 1'b0;
          eBusy = 1'b0;
          if (rstAtEdge) lastOut[i] = 16'h0000;
          if (sbq.size() > 0 && sbq[0].inst == i) begin
            eDone = (sbq[0].fin == cycle);
            eBusy = (sbq[0].fin > cycle);
          end
          checkOutput("busy", i, 16'(busyv[i]), 16'(eBusy));
          checkOutput("done", i, 16'(donev[i]), 16'(eDone));
          if (eDone) begin
            lastOut[i] = sbq[0].prod;
            void'(sbq.pop_front());
          end
          checkOutput("out", i, outv[i], lastOut[i]);
        end
      end
    end
  end

  // Stimulus.
  initial begin
    rst    = 1'b1;
    startv = '0;
    sgnv   = '0;
    av     = '0;
    bv     = '0;
    waitCycles(2);
    rst = 1'b0;

    $display("[TB] directed cases");
    applyStimulus(0, 8'd15, 8'd15, 1'b0);
    applyStimulus(0, 8'h08, 8'h08, 1'b1);
    applyStimulus(0, 8'h0D, 8'h05, 1'b1);
    applyStimulus(0, 8'h0D, 8'h05, 1'b0);

    // A second start while busy must be ignored.
    applyStimulus(0, 8'd7, 8'd3, 1'b0);
    waitCycles(1);
    av[0] = 8'd1;
    bv[0] = 8'd1;
    startv[0] = 1'b1;
    waitCycles(1);
    startv[0] = 1'b0;

    // Hold start high: the next request is accepted in the done cycle.
    while (cycle + 1 < nextOk[0]) waitCycles(1);
    av[0] = 8'd7;
    bv[0] = 8'd3;
    sgnv[0] = 1'b0;
    startv[0] = 1'b1;
    waitCycles(1);
    av[0] = 8'd5;
    bv[0] = 8'd6;
    waitCycles(6);
    startv[0] = 1'b0;

    // Reset at E3 of an operation, with start asserted during reset.
    applyStimulus(0, 8'd9, 8'd9, 1'b0);
    waitCycles(2);
    rst = 1'b1;
    av[0] = 8'd3;
    bv[0] = 8'd3;
    startv[0] = 1'b1;
    waitCycles(1);
    rst = 1'b0;
    startv[0] = 1'b0;
    applyStimulus(0, 8'd9, 8'd9, 1'b0);

    // Latency-sensitive multipliers.
    applyStimulus(0, 8'd5, 8'd0, 1'b0);
    applyStimulus(0, 8'd6, 8'd2, 1'b0);
    applyStimulus(0, 8'd3, 8'd8, 1'b0);
    applyStimulus(0, 8'd3, 8'h08, 1'b1);

    $display("[TB] exhaustive width 4");
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          applyStimulus(0, 8'(a), 8'(b), 1'(s));
        end
      end
    end
    waitIdle(0);

    $display("[TB] random width 8");
    applyStimulus(1, 8'h80, 8'h80, 1'b1);
    applyStimulus(1, 8'hFF, 8'hFF, 1'b0);
    applyStimulus(1, 8'h80, 8'h7F, 1'b1);
    applyStimulus(1, 8'h7F, 8'h80, 1'b1);
    applyStimulus(1, 8'h00, 8'h00, 1'b1);
    for (int n = 0; n < 300; n++) begin
      applyStimulus(1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)));
    end
    waitIdle(1);
    waitCycles(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
